// File: rtl/scheme_deser_pkg.sv
// Shared definitions for the Scheme serializer/deserializer pair:
// receiver state encoding and the default word width.
package scheme_deser_pkg;

  localparam int SCHEME_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/scheme_deser.sv
// Serial-to-parallel receiver for the Scheme bit-serializer stream.
// Rebuilds LSB-first W-bit words framed by start and flags premature syncs.
module scheme_deser
  import scheme_deser_pkg::*;
#(
  parameter int W = SCHEME_W,
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  input  logic          din_en,
  input  logic          start,
  input  logic          clear_err,
  output logic [W-1:0]  data_out,
  output logic          data_valid,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          frame_err
);

  state_t        state_reg, state_next;
  logic [W-2:0]  sreg_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  data_reg;
  logic          valid_reg;
  logic          err_reg;

  logic sync;
  logic last_bit;

  assign sync     = din_en && start;
  assign last_bit = (state_reg == ST_RECV) && din_en && !start
                    && (cnt_reg == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (sync) state_next = ST_RECV;
      ST_RECV: if (last_bit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_reg == ST_RECV);
    data_out   = data_reg;
    data_valid = valid_reg;
    bit_cnt    = cnt_reg;
    frame_err  = err_reg;
  end

  // A sync always restarts the frame at bit 0, whether idle or mid-frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      valid_reg <= last_bit;

      if (sync && (state_reg == ST_RECV)) begin
        err_reg <= 1'b1;
      end else if (clear_err) begin
        err_reg <= 1'b0;
      end

      if (sync) begin
        sreg_reg[0] <= din;
        cnt_reg     <= CW'(1);
      end else if (last_bit) begin
        data_reg <= {din, sreg_reg};
        cnt_reg  <= '0;
      end else if (din_en && (state_reg == ST_RECV)) begin
        for (int i = 1; i < W - 1; i++) begin
          if (cnt_reg == CW'(i)) sreg_reg[i] <= din;
        end
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule
